// File: rtl/ddr_ring_fifo_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared types and MCB constants for the DDR ring FIFO controller.
package ddr_ring_fifo_ctrl_pkg;

    typedef enum logic [2:0] {
        MCB_WRITE    = 3'b000,
        MCB_READ     = 3'b001,
        MCB_WRITE_AP = 3'b010,
        MCB_READ_AP  = 3'b011,
        MCB_REFRESH  = 3'b100
    } mcb_instr_t;

    localparam int MCB_MAX_BL = 64;

    typedef enum logic [1:0] {W_CALIB, W_FILL, W_CMD, W_WAIT} wr_state_t;
    typedef enum logic [1:0] {R_CALIB, R_IDLE, R_CMD, R_DRAIN} rd_state_t;

    // Byte address of a ring slot; each word is 4 bytes.
    function automatic logic [29:0] slot_addr(input logic [29:0] base,
                                              input int unsigned slot,
                                              input int unsigned burst_words);
        return base + 30'(slot * burst_words * 32'd4);
    endfunction

endpackage

// File: rtl/ddr_ring_fifo_ctrl_if.sv
`timescale 1ns/1ps
// Stream and MCB port p0/p2 signals seen by the ring FIFO controller.
// master = the controller, slave = producer/consumer plus the MCB.
interface ddr_ring_fifo_ctrl_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    logic        c3_p0_cmd_en;
    logic [2:0]  c3_p0_cmd_instr;
    logic [5:0]  c3_p0_cmd_bl;
    logic [29:0] c3_p0_cmd_byte_addr;
    logic        c3_p0_cmd_empty;
    logic        c3_p0_cmd_full;
    logic        c3_p0_wr_en;
    logic [3:0]  c3_p0_wr_mask;
    logic [31:0] c3_p0_wr_data;
    logic        c3_p0_wr_full;
    logic        c3_p0_wr_empty;
    logic        c3_p0_wr_underrun;
    logic        c3_p0_wr_error;

    logic        c3_p2_cmd_en;
    logic [2:0]  c3_p2_cmd_instr;
    logic [5:0]  c3_p2_cmd_bl;
    logic [29:0] c3_p2_cmd_byte_addr;
    logic        c3_p2_cmd_full;
    logic        c3_p2_rd_en;
    logic [31:0] c3_p2_rd_data;
    logic        c3_p2_rd_empty;
    logic        c3_p2_rd_overflow;
    logic        c3_p2_rd_error;

    modport master (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid,
        output c3_p0_cmd_en, c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr,
        input  c3_p0_cmd_empty, c3_p0_cmd_full,
        output c3_p0_wr_en, c3_p0_wr_mask, c3_p0_wr_data,
        input  c3_p0_wr_full, c3_p0_wr_empty, c3_p0_wr_underrun, c3_p0_wr_error,
        output c3_p2_cmd_en, c3_p2_cmd_instr, c3_p2_cmd_bl, c3_p2_cmd_byte_addr,
        input  c3_p2_cmd_full,
        output c3_p2_rd_en,
        input  c3_p2_rd_data, c3_p2_rd_empty, c3_p2_rd_overflow, c3_p2_rd_error
    );

    modport slave (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid,
        input  c3_p0_cmd_en, c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr,
        output c3_p0_cmd_empty, c3_p0_cmd_full,
        input  c3_p0_wr_en, c3_p0_wr_mask, c3_p0_wr_data,
        output c3_p0_wr_full, c3_p0_wr_empty, c3_p0_wr_underrun, c3_p0_wr_error,
        input  c3_p2_cmd_en, c3_p2_cmd_instr, c3_p2_cmd_bl, c3_p2_cmd_byte_addr,
        output c3_p2_cmd_full,
        input  c3_p2_rd_en,
        output c3_p2_rd_data, c3_p2_rd_empty, c3_p2_rd_overflow, c3_p2_rd_error
    );
endinterface

// File: rtl/ddr_ring_fifo_ctrl.sv
`timescale 1ns/1ps
// Stream FIFO backed by a ring of DDR bursts: the write FSM packs s_data into bursts on p0,
// the read FSM replays committed bursts from p2 in order; a shared level counts occupied slots.
module ddr_ring_fifo_ctrl
    import ddr_ring_fifo_ctrl_pkg::*;
#(
    parameter int BURST_WORDS  = 32,
    parameter int DEPTH_BURSTS = 1024,
    parameter int BASE_ADDR    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          c3_calib_done,
    ddr_ring_fifo_ctrl_if.master          bus,
    output logic [$clog2(DEPTH_BURSTS):0] level,
    output logic                          full,
    output logic                          empty,
    output logic                          err
);

    localparam int LVL_W = $clog2(DEPTH_BURSTS) + 1;
    localparam int PTR_W = (DEPTH_BURSTS > 1) ? $clog2(DEPTH_BURSTS) : 1;
    localparam int CNT_W = $clog2(MCB_MAX_BL + 1);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_WORDS - 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH_BURSTS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH_BURSTS);
    localparam logic [5:0]       CMD_BL    = 6'(BURST_WORDS - 1);
    localparam logic [29:0]      BASE      = 30'(BASE_ADDR);

    wr_state_t        w_state;
    rd_state_t        r_state;
    logic [CNT_W-1:0] wcnt, rcnt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    logic             p0_cmd_en_q, p2_cmd_en_q;
    mcb_instr_t       p0_instr_q, p2_instr_q;
    logic [5:0]       p0_bl_q, p2_bl_q;
    logic [29:0]      p0_addr_q, p2_addr_q;

    logic             s_ready_c, wr_accept, commit;
    logic             m_valid_c, rd_pop, drain_done;

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);

    // A burst in progress must finish even when the ring is full, hence the wcnt term.
    assign s_ready_c  = (w_state == W_FILL) && !bus.c3_p0_wr_full && ((wcnt != '0) || !full);
    assign wr_accept  = bus.s_valid && s_ready_c;
    assign commit     = (w_state == W_WAIT) && bus.c3_p0_cmd_empty && bus.c3_p0_wr_empty;

    assign m_valid_c  = (r_state == R_DRAIN) && !bus.c3_p2_rd_empty;
    assign rd_pop     = m_valid_c && bus.m_ready;
    assign drain_done = rd_pop && (rcnt == LAST_WORD);

    assign bus.s_ready             = s_ready_c;
    assign bus.c3_p0_wr_en         = wr_accept;
    assign bus.c3_p0_wr_data       = bus.s_data;
    assign bus.c3_p0_wr_mask       = 4'b0000;
    assign bus.c3_p0_cmd_en        = p0_cmd_en_q;
    assign bus.c3_p0_cmd_instr     = p0_instr_q;
    assign bus.c3_p0_cmd_bl        = p0_bl_q;
    assign bus.c3_p0_cmd_byte_addr = p0_addr_q;

    assign bus.m_valid             = m_valid_c;
    assign bus.m_data              = bus.c3_p2_rd_data;
    assign bus.c3_p2_rd_en         = rd_pop;
    assign bus.c3_p2_cmd_en        = p2_cmd_en_q;
    assign bus.c3_p2_cmd_instr     = p2_instr_q;
    assign bus.c3_p2_cmd_bl        = p2_bl_q;
    assign bus.c3_p2_cmd_byte_addr = p2_addr_q;

    // Write side: fill a burst into the p0 write FIFO, issue the command, wait until the MCB drains it.
    // NOTE: state uses non-blocking assignments so every block samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state     <= W_CALIB;
            wcnt        <= '0;
            wr_ptr      <= '0;
            p0_cmd_en_q <= 1'b0;
            p0_instr_q  <= MCB_WRITE;
            p0_bl_q     <= '0;
            p0_addr_q   <= '0;
        end else begin
            p0_cmd_en_q <= 1'b0;
            case (w_state)
                W_CALIB: if (c3_calib_done) w_state <= W_FILL;
                W_FILL: begin
                    if (wr_accept) begin
                        if (wcnt == LAST_WORD) begin
                            wcnt    <= '0;
                            w_state <= W_CMD;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                W_CMD: begin
                    if (!bus.c3_p0_cmd_full) begin
                        p0_cmd_en_q <= 1'b1;
                        p0_instr_q  <= MCB_WRITE;
                        p0_bl_q     <= CMD_BL;
                        p0_addr_q   <= slot_addr(BASE, 32'(wr_ptr), BURST_WORDS);
                        wr_ptr      <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
                        w_state     <= W_WAIT;
                    end
                end
                W_WAIT: if (commit) w_state <= W_FILL;
                default: w_state <= W_CALIB;
            endcase
        end
    end

    // Read side: one p2 read outstanding; the slot stays counted in level until fully drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= R_CALIB;
            rcnt        <= '0;
            rd_ptr      <= '0;
            p2_cmd_en_q <= 1'b0;
            p2_instr_q  <= MCB_WRITE;
            p2_bl_q     <= '0;
            p2_addr_q   <= '0;
        end else begin
            p2_cmd_en_q <= 1'b0;
            case (r_state)
                R_CALIB: if (c3_calib_done) r_state <= R_IDLE;
                R_IDLE: begin
                    if (!empty && !bus.c3_p2_cmd_full) begin
                        p2_cmd_en_q <= 1'b1;
                        p2_instr_q  <= MCB_READ;
                        p2_bl_q     <= CMD_BL;
                        p2_addr_q   <= slot_addr(BASE, 32'(rd_ptr), BURST_WORDS);
                        r_state     <= R_CMD;
                    end
                end
                R_CMD: r_state <= R_DRAIN;
                R_DRAIN: begin
                    if (drain_done) begin
                        rcnt    <= '0;
                        rd_ptr  <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
                        r_state <= R_IDLE;
                    end else if (rd_pop) begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: r_state <= R_CALIB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            err   <= 1'b0;
        end else begin
            case ({commit, drain_done})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (bus.c3_p0_wr_underrun || bus.c3_p0_wr_error ||
                bus.c3_p2_rd_overflow || bus.c3_p2_rd_error)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_ring_fifo_ctrl.sv
`timescale 1ns/1ps
// Bench for ddr_ring_fifo_ctrl: a small MCB model with p0/p2 queues and a word-addressed DDR image;
// the expected output stream is the input stream in order.
module tb_ddr_ring_fifo_ctrl;

    localparam int BW    = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       calib;
    logic [2:0] level;
    logic       full, empty, err;

    ddr_ring_fifo_ctrl_if bus ();

    ddr_ring_fifo_ctrl #(
        .BURST_WORDS (BW),
        .DEPTH_BURSTS(DEPTH),
        .BASE_ADDR   (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .c3_calib_done(calib),
        .bus          (bus),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        int          words;
        int          due;
    } mcb_cmd_t;

    typedef struct {
        int push_bursts;
        int exp_level;
        bit exp_full;
        bit exp_s_ready;
        int exp_tx_left;
    } fill_vec_t;

    logic [31:0] tx_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] stage[$];
    logic [31:0] rd_q[$];
    mcb_cmd_t    pw[$];
    mcb_cmd_t    pr[$];
    logic [31:0] mem[int];

    int          checks, errors;
    int          cyc;
    int          exp_wslot, exp_rslot;
    int          n_p0, n_p2;
    logic [31:0] next_word;
    logic [29:0] last_p0_addr;
    bit          jitter, sink_en;
    bit          saw_ready, saw_cmd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_burst();
        for (int i = 0; i < BW; i++) begin
            tx_q.push_back(next_word);
            exp_q.push_back(next_word);
            next_word++;
        end
    endtask

    // One clock: drive model outputs at the negedge, then record what the DUT does at the next posedge.
    task automatic step();
        mcb_cmd_t c;
        @(negedge clk);
        bus.c3_p0_cmd_empty = (pw.size() == 0);
        bus.c3_p0_wr_empty  = (stage.size() == 0);
        bus.c3_p0_cmd_full  = jitter && ($urandom_range(0, 3) == 0);
        bus.c3_p0_wr_full   = jitter && ($urandom_range(0, 5) == 0);
        bus.c3_p2_cmd_full  = jitter && ($urandom_range(0, 3) == 0);
        bus.c3_p2_rd_empty  = (rd_q.size() == 0);
        bus.c3_p2_rd_data   = (rd_q.size() != 0) ? rd_q[0] : 32'h0;
        bus.s_valid         = (tx_q.size() != 0);
        bus.s_data          = (tx_q.size() != 0) ? tx_q[0] : 32'h0;
        bus.m_ready         = sink_en && (!jitter || ($urandom_range(0, 2) != 0));
        #1;
        if (bus.s_ready) saw_ready = 1'b1;
        if (bus.c3_p0_cmd_en || bus.c3_p2_cmd_en) saw_cmd = 1'b1;
        if (bus.s_valid && bus.s_ready) void'(tx_q.pop_front());
        if (bus.c3_p0_wr_en) begin
            stage.push_back(bus.c3_p0_wr_data);
            check("p0_wr_mask", 32'(bus.c3_p0_wr_mask), 32'h0);
        end
        if (bus.c3_p0_cmd_en) begin
            check("p0_instr", 32'(bus.c3_p0_cmd_instr), 32'h0);
            check("p0_bl", 32'(bus.c3_p0_cmd_bl), 32'(BW - 1));
            check("p0_addr", 32'(bus.c3_p0_cmd_byte_addr), 32'(exp_wslot * BW * 4));
            exp_wslot    = (exp_wslot + 1) % DEPTH;
            last_p0_addr = bus.c3_p0_cmd_byte_addr;
            n_p0++;
            c.addr = bus.c3_p0_cmd_byte_addr;
            c.words = int'(bus.c3_p0_cmd_bl) + 1;
            c.due = cyc + 3;
            pw.push_back(c);
        end
        if (bus.c3_p2_cmd_en) begin
            check("p2_instr", 32'(bus.c3_p2_cmd_instr), 32'h1);
            check("p2_bl", 32'(bus.c3_p2_cmd_bl), 32'(BW - 1));
            check("p2_addr", 32'(bus.c3_p2_cmd_byte_addr), 32'(exp_rslot * BW * 4));
            exp_rslot = (exp_rslot + 1) % DEPTH;
            n_p2++;
            c.addr = bus.c3_p2_cmd_byte_addr;
            c.words = int'(bus.c3_p2_cmd_bl) + 1;
            c.due = cyc + 3;
            pr.push_back(c);
        end
        if (bus.c3_p2_rd_en) begin
            if (exp_q.size() == 0) check("m_data_extra", bus.m_data, 32'hFFFF_FFFF);
            else check("m_data", bus.m_data, exp_q.pop_front());
            if (rd_q.size() != 0) void'(rd_q.pop_front());
        end
        if (pw.size() != 0 && pw[0].due <= cyc) begin
            for (int i = 0; i < pw[0].words; i++)
                mem[int'(pw[0].addr >> 2) + i] = (stage.size() != 0) ? stage.pop_front() : 32'hBAD0_BAD0;
            void'(pw.pop_front());
        end
        if (pr.size() != 0 && pr[0].due <= cyc) begin
            for (int i = 0; i < pr[0].words; i++) begin
                int k = int'(pr[0].addr >> 2) + i;
                rd_q.push_back(mem.exists(k) ? mem[k] : 32'hDEAD_BEEF);
            end
            void'(pr.pop_front());
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain(input int budget, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_p0_cmd_en"}, 32'(bus.c3_p0_cmd_en), 32'h0);
        check({tag, "_p2_cmd_en"}, 32'(bus.c3_p2_cmd_en), 32'h0);
        check({tag, "_p0_instr"}, 32'(bus.c3_p0_cmd_instr), 32'h0);
        check({tag, "_p2_instr"}, 32'(bus.c3_p2_cmd_instr), 32'h0);
        check({tag, "_p0_bl"}, 32'(bus.c3_p0_cmd_bl), 32'h0);
        check({tag, "_p2_addr"}, 32'(bus.c3_p2_cmd_byte_addr), 32'h0);
        check({tag, "_p0_addr"}, 32'(bus.c3_p0_cmd_byte_addr), 32'h0);
        check({tag, "_wr_en"}, 32'(bus.c3_p0_wr_en), 32'h0);
        check({tag, "_rd_en"}, 32'(bus.c3_p2_rd_en), 32'h0);
        check({tag, "_s_ready"}, 32'(bus.s_ready), 32'h0);
        check({tag, "_m_valid"}, 32'(bus.m_valid), 32'h0);
        check({tag, "_level"}, 32'(level), 32'h0);
        check({tag, "_empty"}, 32'(empty), 32'h1);
        check({tag, "_full"}, 32'(full), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_vec_t vecs[5];
        bit        seen;

        vecs[0] = '{1, 1, 1'b0, 1'b1, 0};
        vecs[1] = '{1, 2, 1'b0, 1'b1, 0};
        vecs[2] = '{1, 3, 1'b0, 1'b1, 0};
        vecs[3] = '{1, 4, 1'b1, 1'b0, 0};
        vecs[4] = '{1, 4, 1'b1, 1'b0, 4};

        checks = 0; errors = 0; cyc = 0;
        exp_wslot = 0; exp_rslot = 0; n_p0 = 0; n_p2 = 0;
        next_word = 32'h0; jitter = 1'b0; sink_en = 1'b0;
        rst_n = 1'b0; calib = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        bus.c3_p0_cmd_empty = 1'b1; bus.c3_p0_cmd_full = 1'b0;
        bus.c3_p0_wr_full = 1'b0; bus.c3_p0_wr_empty = 1'b1;
        bus.c3_p0_wr_underrun = 1'b0; bus.c3_p0_wr_error = 1'b0;
        bus.c3_p2_cmd_full = 1'b0; bus.c3_p2_rd_data = '0; bus.c3_p2_rd_empty = 1'b1;
        bus.c3_p2_rd_overflow = 1'b0; bus.c3_p2_rd_error = 1'b0;

        run(3);
        check_reset("por");
        rst_n = 1'b1;

        // Uncalibrated: words are offered but nothing may move.
        saw_ready = 1'b0; saw_cmd = 1'b0;
        push_burst();
        run(100);
        check("t4_s_ready", 32'(saw_ready), 32'h0);
        check("t4_cmd_en", 32'(saw_cmd), 32'h0);
        check("t4_tx_left", 32'(tx_q.size()), 32'(BW));

        // Single burst 0..3 through slot 0.
        calib = 1'b1;
        sink_en = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (level == 3'd1) seen = 1'b1;
        end
        check("t1_level_one", 32'(seen), 32'h1);
        drain(60, "t1_drain");
        run(5);
        check("t1_p0_cmds", 32'(n_p0), 32'h1);
        check("t1_p2_cmds", 32'(n_p2), 32'h1);
        check("t1_level", 32'(level), 32'h0);
        check("t1_empty", 32'(empty), 32'h1);

        // Fill to full with the consumer stalled, one burst per vector.
        sink_en = 1'b0;
        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < vecs[v].push_bursts; b++) push_burst();
            run(30);
            check($sformatf("t2_level_%0d", v), 32'(level), 32'(vecs[v].exp_level));
            check($sformatf("t2_full_%0d", v), 32'(full), 32'(vecs[v].exp_full));
            check($sformatf("t2_empty_%0d", v), 32'(empty), 32'h0);
            check($sformatf("t2_s_ready_%0d", v), 32'(bus.s_ready), 32'(vecs[v].exp_s_ready));
            check($sformatf("t2_tx_left_%0d", v), 32'(tx_q.size()), 32'(vecs[v].exp_tx_left));
        end
        sink_en = 1'b1;
        drain(400, "t2_drain");
        run(10);
        check("t2_level_end", 32'(level), 32'h0);

        // Wrap the ring ten times with random back-pressure everywhere.
        n_p0 = 0; n_p2 = 0;
        jitter = 1'b1;
        for (int b = 0; b < 40; b++) push_burst();
        drain(6000, "t3_drain");
        jitter = 1'b0;
        run(10);
        check("t3_p0_cmds", 32'(n_p0), 32'd40);
        check("t3_p2_cmds", 32'(n_p2), 32'd40);
        check("t3_err", 32'(err), 32'h0);
        check("t3_empty", 32'(empty), 32'h1);

        // One-cycle overflow pulse: err sticks, data keeps flowing.
        push_burst();
        push_burst();
        run(5);
        bus.c3_p2_rd_overflow = 1'b1;
        step();
        bus.c3_p2_rd_overflow = 1'b0;
        run(1);
        check("t6_err_set", 32'(err), 32'h1);
        drain(200, "t6_drain");
        run(10);
        check("t6_err_sticky", 32'(err), 32'h1);

        // Reset while the read side is mid-drain.
        sink_en = 1'b0;
        push_burst();
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            step();
            if (bus.m_valid) seen = 1'b1;
        end
        check("t5_in_drain", 32'(seen), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset("t5");
        tx_q.delete(); exp_q.delete(); stage.delete(); rd_q.delete();
        pw.delete(); pr.delete(); mem.delete();
        exp_wslot = 0; exp_rslot = 0;
        run(2);
        rst_n = 1'b1;
        last_p0_addr = '1;
        sink_en = 1'b1;
        push_burst();
        drain(100, "t5_drain");
        run(5);
        check("t5_first_addr", 32'(last_p0_addr), 32'h0);
        check("t5_level", 32'(level), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
